pulse_width_meter: RTL and testbench
====================================

Name: pulse_width_meter

Overview:
- Receive-side counterpart to the free-running 6-bit counter: it converts an incoming pulse into a cycle count instead of generating a count from the clock.
- Measures the high time of an asynchronous input pulse (limit switch, encoder or servo feedback on the drawing robot) in clk cycles.
- Presents the result through a valid/ready handshake to the processor I/O logic.
- Width is 6 bits by default, saturating, with an overflow flag.

Parameters:
- WIDTH, 6, bit width of the measurement counter and result; saturation value is 2^WIDTH-1.
- SYNC_STAGES, 2, number of flops in the input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- en  in  1  measurement enable; 0 aborts any measurement in progress.
- sig_in  in  1  asynchronous pulse input.
- width  out  WIDTH  measured high time in clk cycles; valid while res_valid=1.
- ovf  out  1  result saturated; qualified by res_valid.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- missed  out  1  one-cycle strobe: a rising edge arrived while a result was pending.

Behaviour:
- Reset (rst=0, async): state=IDLE, width=0, ovf=0, res_valid=0, missed=0, counter=0, synchroniser flops=0, s_prev=0.
- Synchroniser: s = sig_in delayed SYNC_STAGES cycles. rise = s & ~s_prev; fall = ~s & s_prev.
- en=0 in any state other than HOLD: go to IDLE, counter cleared, no result produced.
- en=0 in HOLD: the pending result is retained until accepted.
- States:
  - IDLE: if en & ~s, go to ARMED. A pulse already high at enable is never measured.
  - ARMED: on rise, go to MEASURE with counter=1.
  - MEASURE, s=1: counter += 1. At 2^WIDTH-1 the counter holds and the ovf latch is set.
  - MEASURE, s=0 (fall): width<=counter, ovf<=latch, res_valid<=1, go to HOLD.
  - HOLD: res_valid=1, width/ovf stable. On res_ready, res_valid<=0 next cycle and the ovf latch clears. Next state is ARMED if en & ~s, IDLE otherwise.
- Measurement rule: a pulse high for N synchronised cycles yields width=N for N ≤ 2^WIDTH-1. For N ≥ 2^WIDTH, width=2^WIDTH-1 and ovf=1.
- Latency: res_valid asserts 1 cycle after fall is seen, i.e. SYNC_STAGES+1 cycles after sig_in falls.
- Back-to-back pulses: res_ready asserted in the same cycle res_valid rises counts as acceptance. There is no pipelining; one result is outstanding at most.
- missed: in HOLD, rise asserts missed for exactly 1 cycle and the pulse is dropped. Multiple rises give multiple strobes.
- Reset mid-measurement or mid-HOLD: the result is discarded and all outputs return to reset values asynchronously.
- Glitches shorter than 1 cycle after synchronisation are not detected. A 1-cycle synchronised pulse yields width=1.

Decomposition:
- Shared package pwm_meter_pkg:
  - state enum {IDLE, ARMED, MEASURE, HOLD};
  - localparam default WIDTH=6;
  - derived MAX_COUNT constant.
- One sub-module sig_sync:
  - SYNC_STAGES flop chain plus s_prev register;
  - outputs s, rise, fall;
  - same clk/rst (active-low async).
- Top holds the FSM, counter, ovf latch and output registers.

Test Plan:
- Reset/idle: hold rst=0 while sig_in toggles, then release with en=1 and sig_in=0 → all outputs 0; state reaches ARMED within 1 cycle.
- Nominal: en=1, sig_in high for 10 clk cycles (clk-aligned), res_ready=1 → res_valid pulses 1 cycle, width=10, ovf=0, exactly SYNC_STAGES+1 cycles after the falling edge.
- Saturation: sig_in high for 100 cycles → width=63, ovf=1. Next pulse of 5 cycles → width=5, ovf=0.
- Backpressure/missed: res_ready=0, pulse of 7 then pulse of 3 → width=7 held stable; missed=1 for one cycle. Then assert res_ready → res_valid drops, no result for the 3-cycle pulse.
- Abort/enable: en=0 mid-pulse → no res_valid. Enable while sig_in already high → that pulse is ignored; the next 4-cycle pulse gives width=4.
- Async reset mid-HOLD: assert rst=0 between clk edges while res_valid=1 → res_valid, width, ovf go to 0 immediately without a clock edge.

Source files
------------

// File: rtl/pwm_meter_pkg.sv
// pwm_meter_pkg: shared FSM state type, default width and saturation helper for pulse_width_meter
package pwm_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, HOLD} state_t;
  localparam int DEF_WIDTH = 6;
  function automatic int max_count(input int w);
    return (1 << w) - 1;
  endfunction
  localparam int MAX_COUNT = max_count(DEF_WIDTH);
endpackage

// File: rtl/pulse_width_meter_sig_sync.sv
// sig_sync: SYNC_STAGES-flop synchroniser for sig_in giving s plus one-cycle rise/fall strobes, async active-low rst
module sig_sync
  import pwm_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end
  assign s    = r_sync[SYNC_STAGES-1];
  assign rise = s & ~r_prev;
  assign fall = ~s & r_prev;
endmodule

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: counts sig_in high time in clk cycles (saturating, ovf flag), result via width/ovf/res_valid/res_ready, missed strobes pulses dropped while a result is pending
module pulse_width_meter
  import pwm_meter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] width,
  output logic             ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             missed
);
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(max_count(WIDTH));
  logic             w_s, w_rise, w_fall;
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_cnt, w_cnt_nx, r_width, w_width_nx;
  logic             r_lat, w_lat_nx, r_ovf, w_ovf_nx, r_valid, w_valid_nx, r_missed, w_missed_nx;
  sig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .s      (w_s),
    .rise   (w_rise),
    .fall   (w_fall)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_lat    <= 1'b0;
      r_width  <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_lat    <= w_lat_nx;
      r_width  <= w_width_nx;
      r_ovf    <= w_ovf_nx;
      r_valid  <= w_valid_nx;
      r_missed <= w_missed_nx;
    end
  end
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_lat_nx    = r_lat;
    w_width_nx  = r_width;
    w_ovf_nx    = r_ovf;
    w_valid_nx  = r_valid;
    w_missed_nx = 1'b0;
    case (r_state)
      IDLE: w_state_nx = (en && !w_s) ? ARMED : IDLE;
      ARMED: begin
        if (!en) begin
          w_state_nx = IDLE;
        end else if (w_rise) begin
          w_state_nx = MEASURE;
          w_cnt_nx   = WIDTH'(1);
          w_lat_nx   = 1'b0;
        end
      end
      MEASURE: begin
        if (!en) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
          w_lat_nx   = 1'b0;
        end else if (w_s) begin
          w_lat_nx = r_lat | (r_cnt == L_MAX);
          w_cnt_nx = (r_cnt == L_MAX) ? r_cnt : r_cnt + WIDTH'(1);
        end else if (w_fall) begin
          w_state_nx = HOLD;
          w_width_nx = r_cnt;
          w_ovf_nx   = r_lat;
          w_valid_nx = 1'b1;
          w_cnt_nx   = '0;
        end
      end
      HOLD: begin
        w_missed_nx = w_rise;
        if (res_ready) begin
          w_valid_nx = 1'b0;
          w_lat_nx   = 1'b0;
          w_state_nx = (en && !w_s) ? ARMED : IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end
  assign width     = r_width;
  assign ovf       = r_ovf;
  assign res_valid = r_valid;
  assign missed    = r_missed;
endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: randomized and directed scenarios for pulse_width_meter checked against a pulse-length reference model
module tb_pulse_width_meter;
  import pwm_meter_pkg::*;
  localparam int SYNC = 2;
  logic       clk = 1'b0;
  logic       rst, en, sig_in, res_ready;
  logic [5:0] width;
  logic       ovf, res_valid, missed;
  int         passed = 0;
  int         total = 0;
  pulse_width_meter #(.WIDTH(DEF_WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .width     (width),
    .ovf       (ovf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .missed    (missed)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  function automatic logic [6:0] ref_meas(input int n);
    logic [5:0] w;
    w = (n > MAX_COUNT) ? 6'(MAX_COUNT) : 6'(n);
    return {n > MAX_COUNT, w};
  endfunction
  task automatic pulse(input int n);
    sig_in = 1'b1;
    repeat (n) @(negedge clk);
    sig_in = 1'b0;
  endtask
  task automatic wait_valid(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      got = res_valid;
    end
  endtask
  task automatic test_reset;
    rst = 1'b0; en = 1'b1; res_ready = 1'b0; sig_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sig_in = 1'($urandom_range(0, 1));
      total++;
      if ({res_valid, width, ovf, missed} !== 9'd0) $display("FAIL reset_hold: got %b required 0", {res_valid, width, ovf, missed});
      else passed++;
    end
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({res_valid, width, ovf, missed} !== 9'd0) $display("FAIL reset_release: got %b required 0", {res_valid, width, ovf, missed});
    else passed++;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_nominal;
    int c; bit g;
    res_ready = 1'b1;
    pulse(10);
    wait_valid(c, g);
    total++; if (!g) $display("FAIL nominal_valid: got 0 required 1"); else passed++;
    total++; if (c !== SYNC + 1) $display("FAIL nominal_latency: got %0d required %0d", c, SYNC + 1); else passed++;
    total++; if (width !== 6'd10) $display("FAIL nominal_width: got %0d required 10", width); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL nominal_ovf: got %b required 0", ovf); else passed++;
    @(negedge clk);
    total++; if (res_valid !== 1'b0) $display("FAIL nominal_one_cycle: got %b required 0", res_valid); else passed++;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_saturation;
    int c; bit g;
    logic [6:0] e;
    res_ready = 1'b1;
    e = ref_meas(100);
    pulse(100);
    wait_valid(c, g);
    total++; if (!g) $display("FAIL sat_valid: got 0 required 1"); else passed++;
    total++; if ({ovf, width} !== e) $display("FAIL sat_result: got ovf=%b width=%0d required ovf=%b width=%0d", ovf, width, e[6], e[5:0]); else passed++;
    repeat (4) @(negedge clk);
    pulse(5);
    wait_valid(c, g);
    total++; if (!g) $display("FAIL sat_next_valid: got 0 required 1"); else passed++;
    total++; if ({ovf, width} !== {1'b0, 6'd5}) $display("FAIL sat_next_result: got ovf=%b width=%0d required ovf=0 width=5", ovf, width); else passed++;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_back_to_back;
    int c, m, v; bit g, stable;
    res_ready = 1'b0;
    pulse(7);
    wait_valid(c, g);
    total++; if (!g || width !== 6'd7) $display("FAIL bp_first: got valid=%b width=%0d required valid=1 width=7", g, width); else passed++;
    m = 0; stable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sig_in = (i >= 3 && i < 6);
      @(negedge clk);
      m += int'(missed);
      if (!res_valid || width !== 6'd7 || ovf !== 1'b0) stable = 1'b0;
    end
    total++; if (!stable) $display("FAIL bp_stable: got unstable result required width=7 held"); else passed++;
    total++; if (m !== 1) $display("FAIL bp_missed: got %0d strobes required 1", m); else passed++;
    res_ready = 1'b1;
    @(negedge clk);
    total++; if (res_valid !== 1'b0) $display("FAIL bp_accept: got %b required 0", res_valid); else passed++;
    v = 0;
    repeat (8) begin @(negedge clk); v += int'(res_valid); end
    total++; if (v !== 0) $display("FAIL bp_dropped: got %0d valid cycles required 0", v); else passed++;
  endtask
  task automatic test_abort;
    int c, v; bit g;
    res_ready = 1'b1;
    v = 0;
    for (int i = 0; i < 20; i++) begin
      en = !(i >= 6 && i < 13);
      sig_in = (i < 9);
      @(negedge clk);
      v += int'(res_valid);
    end
    total++; if (v !== 0) $display("FAIL abort_midpulse: got %0d valid cycles required 0", v); else passed++;
    v = 0;
    for (int i = 0; i < 16; i++) begin
      en = (i >= 4);
      sig_in = (i < 10);
      @(negedge clk);
      v += int'(res_valid);
    end
    total++; if (v !== 0) $display("FAIL abort_high_at_enable: got %0d valid cycles required 0", v); else passed++;
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    pulse(4);
    wait_valid(c, g);
    total++; if (!g) $display("FAIL abort_next_valid: got 0 required 1"); else passed++;
    total++; if ({ovf, width} !== {1'b0, 6'd4}) $display("FAIL abort_next_result: got ovf=%b width=%0d required ovf=0 width=4", ovf, width); else passed++;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_async_reset;
    int c; bit g;
    res_ready = 1'b0;
    pulse(70);
    wait_valid(c, g);
    total++; if (!g || {ovf, width} !== {1'b1, 6'd63}) $display("FAIL areset_pre: got valid=%b ovf=%b width=%0d required 1 1 63", g, ovf, width); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if ({res_valid, width, ovf, missed} !== 9'd0) $display("FAIL areset_async: got %b required 0", {res_valid, width, ovf, missed}); else passed++;
    @(negedge clk);
    rst = 1'b1;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (res_valid !== 1'b0) $display("FAIL areset_after: got %b required 0", res_valid); else passed++;
  endtask
  task automatic test_random;
    int n, gap, hold, c; bit g, stable;
    logic [6:0] e;
    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(1, 90);
      gap = $urandom_range(3, 6);
      hold = $urandom_range(0, 3);
      e = ref_meas(n);
      res_ready = 1'b0;
      sig_in = 1'b0;
      repeat (gap) @(negedge clk);
      pulse(n);
      wait_valid(c, g);
      total++; if (!g) $display("FAIL rand_valid n=%0d: got 0 required 1", n); else passed++;
      total++; if (c !== SYNC + 1) $display("FAIL rand_latency n=%0d: got %0d required %0d", n, c, SYNC + 1); else passed++;
      total++; if ({ovf, width} !== e) $display("FAIL rand_result n=%0d: got ovf=%b width=%0d required ovf=%b width=%0d", n, ovf, width, e[6], e[5:0]); else passed++;
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!res_valid || {ovf, width} !== e) stable = 1'b0;
      end
      total++; if (!stable) $display("FAIL rand_hold n=%0d: got unstable result required held", n); else passed++;
      res_ready = 1'b1;
      @(negedge clk);
      total++; if (res_valid !== 1'b0) $display("FAIL rand_accept n=%0d: got %b required 0", n, res_valid); else passed++;
    end
    res_ready = 1'b0;
  endtask
  initial begin
    test_reset;
    test_nominal;
    test_saturation;
    test_back_to_back;
    test_abort;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
